// File: rtl/store_write_buffer_pkg.sv
// Shared MIPS opcode constants and store-queue entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_write_buffer_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam int BE_W = 4;

  // One queued store: word address, lane-replicated data, byte enables.
  typedef struct packed {
    logic [29:0]     waddr;
    logic [31:0]     wdata;
    logic [BE_W-1:0] be;
  } st_entry_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// Data-memory write port: one request held until acknowledged.
// Latency: n/a (signal bundle).
// Backpressure: master holds mem_req and payload stable until mem_ack.
interface store_write_buffer_if;
  import store_write_buffer_pkg::*;

  logic            mem_req;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            mem_ack;

  modport master (output mem_req, mem_addr, mem_wdata, mem_be, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_wdata, mem_be, output mem_ack);
endinterface

// File: rtl/store_write_buffer_align.sv
// Store/load decode, misalignment detect, byte-enable and lane-replicated data.
// Latency: combinational.
// Backpressure: none; pure function of the MEM-stage inputs.
module store_align
  import store_write_buffer_pkg::*;
(
  input  logic            valid,
  input  logic [5:0]      opcode,
  input  logic [1:0]      a,
  input  logic [31:0]     wd,
  output logic            is_store,
  output logic            is_load,
  output logic            ades,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata
);

  // Decode the opcode and build enables/data for the addressed lanes.
  always_comb begin
    is_store = 1'b0;
    is_load  = 1'b0;
    ades     = 1'b0;
    be       = '0;
    wdata    = wd;
    case (opcode)
      OP_SB: begin
        is_store = 1'b1;
        be       = 4'b0001 << a;
        wdata    = {4{wd[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        be       = a[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{wd[15:0]}};
        ades     = valid & a[0];
      end
      OP_SW: begin
        is_store = 1'b1;
        be       = 4'b1111;
        wdata    = wd;
        ades     = valid & (a != 2'b00);
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// MEM-stage store queue: decodes stores, buffers them and drains to memory in order.
// Latency: a store pushed at edge N raises mem_req at edge N+2 at the earliest.
// Backpressure: Stall when the queue is full or a load hits a pending word; mem_* held until mem_ack.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  Valid3,
  input  logic [31:0]           Instr3,
  input  logic [31:0]           Addr3,
  input  logic [31:0]           WD3,
  output logic                  Stall,
  output logic                  AdES,
  output logic                  Empty,
  output logic [CNT_W-1:0]      Count,
  store_write_buffer_if.master  mem
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  logic            is_store, is_load, ades;
  logic [BE_W-1:0] st_be;
  logic [31:0]     st_wdata;

  st_entry_t        fifo_q [DEPTH];
  st_entry_t        entry_in, head, head_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             avail_q;
  logic             full, push, pop, load_hit;
  logic [DEPTH-1:0] hit_vec;
  state_t           state;

  store_align u_align (
    .valid    (Valid3),
    .opcode   (Instr3[31:26]),
    .a        (Addr3[1:0]),
    .wd       (WD3),
    .is_store (is_store),
    .is_load  (is_load),
    .ades     (ades),
    .be       (st_be),
    .wdata    (st_wdata)
  );

  // Full is taken from the registered count only, keeping mem_ack off the Stall path.
  assign full     = (cnt == CNT_W'(DEPTH));
  assign push     = Valid3 & is_store & ~ades & ~full;
  assign pop      = (state == S_REQ) & mem.mem_ack;
  assign entry_in = '{waddr: Addr3[31:2], wdata: st_wdata, be: st_be};
  assign head     = fifo_q[rd_ptr];
  assign head_nxt = fifo_q[rd_ptr + PTR_W'(1)];

  // An entry is live when its distance from the read pointer is below the count;
  // the in-flight head stays live until its ack pops it.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hz
    logic [PTR_W-1:0] offs;
    assign offs       = PTR_W'(g) - rd_ptr;
    assign hit_vec[g] = (CNT_W'(offs) < cnt) && (fifo_q[g].waddr == Addr3[31:2]);
  end
  assign load_hit = |hit_vec;

  assign AdES  = ades;
  assign Stall = Valid3 & ((is_store & ~ades & full) | (is_load & load_hit));
  assign Empty = (cnt == '0) & ~mem.mem_req;
  assign Count = cnt;

  // Queue storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= entry_in;
  end

  // Pointers, occupancy, and the "settled head" flag that gates a fresh launch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      avail_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      // Only entries already present before this edge and not popped count as
      // settled, so a freshly pushed store waits one extra cycle before launch.
      avail_q <= (cnt > CNT_W'(pop));
    end
  end

  // Drain FSM: launch the head, hold until ack, chain the next entry without a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (avail_q && (cnt != '0)) begin
            mem.mem_req   <= 1'b1;
            mem.mem_addr  <= {head.waddr, 2'b00};
            mem.mem_wdata <= head.wdata;
            mem.mem_be    <= head.be;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem.mem_ack) begin
            if (cnt > CNT_W'(1)) begin
              mem.mem_addr  <= {head_nxt.waddr, 2'b00};
              mem.mem_wdata <= head_nxt.wdata;
              mem.mem_be    <= head_nxt.be;
            end else begin
              mem.mem_req <= 1'b0;
              state       <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
